rv_multicycle_ctrl: RTL and testbench
=====================================

# rv_multicycle_ctrl

Multi-cycle control FSM for the RV32I core. It sequences instruction fetch, decode, execute, memory and writeback around the combinational instruction decoder, ALU, register file and memories. It drives all datapath enables and mux selects and handles the instruction- and data-memory request/acknowledge handshakes. It also detects illegal opcodes and memory time-outs, and keeps a retired-instruction counter.

## Interface
Parameters:
- MEM_TIMEOUT, 255: cycles a memory request may wait for its ack before a fault; valid range 1..255.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- opcode  input  7  opcode field from the decoder, taken from the instruction register.
- branch_taken  input  1  ALU branch-compare result, valid in EXEC.
- imem_ack  input  1  instruction memory has data; one-cycle pulse.
- dmem_ack  input  1  data memory access complete; one-cycle pulse.
- imem_req  output  1  instruction fetch request.
- ir_we  output  1  instruction register load.
- pc_we  output  1  PC update; marks retirement.
- pc_sel  output  2  PC source: 0 = pc+4, 1 = pc+imm (branch), 2 = pc+label (JAL), 3 = ALU result (JALR).
- alu_a_sel  output  1  0 = rs1, 1 = pc.
- alu_b_sel  output  1  0 = rs2, 1 = imm.
- reg_we  output  1  register-file write.
- wb_sel  output  2  write-back source: 0 = ALU, 1 = dmem data, 2 = pc+4, 3 = label (LUI).
- dmem_req  output  1  data memory request.
- dmem_we  output  1  data memory write (store); valid with dmem_req.
- fault  output  1  FSM is in TRAP.
- fault_code  output  2  0 = none, 1 = illegal opcode, 2 = imem timeout, 3 = dmem timeout.
- instret  output  32  retired-instruction count.
- state  output  3  current state, for debug.

## Operation
- State encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 7.
- All outputs except `fault_code`, `instret` and `state` are combinational from the state, the latched class register and the acks. Outputs not listed for a state are 0.
- **FETCH**
  - `imem_req` = 1.
  - On `imem_ack`: `ir_we` = 1 in the same cycle, next state is DECODE.
- **DECODE**
  - Classify `opcode` into `cls`, held in a register:
    - 0110011 → R
    - 0010011 → I
    - 0000011 → LD
    - 0100011 → ST
    - 1100011 → BR
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 → LUI
    - 0010111 → AUIPC
  - Next state is EXEC. Any other opcode goes to TRAP with `fault_code` = 1.
- **EXEC** (one cycle)
  - R: `alu_b_sel` = 0; next WB.
  - I, LD, ST: `alu_b_sel` = 1; I goes to WB, LD and ST go to MEM.
  - AUIPC: `alu_a_sel` = 1, `alu_b_sel` = 1; next WB.
  - LUI: next WB.
  - BR: `alu_b_sel` = 0, `pc_we` = 1, `pc_sel` = `branch_taken` ? 1 : 0; next FETCH.
  - JAL: `pc_we` = 1, `pc_sel` = 2, `reg_we` = 1, `wb_sel` = 2; next FETCH.
  - JALR: `alu_b_sel` = 1, `pc_we` = 1, `pc_sel` = 3, `reg_we` = 1, `wb_sel` = 2; next FETCH.
- **MEM**
  - `dmem_req` = 1; `dmem_we` = 1 when `cls` = ST; `alu_b_sel` = 1 is held.
  - On `dmem_ack`: LD goes to WB; ST asserts `pc_we` = 1 with `pc_sel` = 0 and goes to FETCH.
- **WB** (one cycle)
  - `reg_we` = 1 and `pc_we` = 1 with `pc_sel` = 0.
  - `wb_sel`: 1 for LD, 3 for LUI, 0 otherwise.
  - Selects stay as in EXEC for R, I and AUIPC.
  - Next state is FETCH.
- **TRAP**
  - All enables and requests are 0; `fault` = 1.
  - Held until `rst_n` = 0.
- **Timeout**
  - An 8-bit wait counter clears on every state change and increments each cycle in FETCH or MEM while the ack is low.
  - When it equals MEM_TIMEOUT with the ack still low, the next state is TRAP, with `fault_code` = 2 from FETCH or 3 from MEM.
  - An ack arriving in that same cycle wins: no fault.
- **instret**
  - Increments by 1 on every cycle with `pc_we` = 1.
  - Wraps from 0xFFFFFFFF to 0.

## Timing
- Reset: on a clock edge with `rst_n` = 0, `state` = FETCH, `cls` = R, wait counter = 0, `fault_code` = 0, `instret` = 0. Reset from any state, mid-handshake included, drops `dmem_req` and `imem_req` in the next cycle, then `imem_req` = 1 again in FETCH.
- Minimum latency with acks in the same cycle as the request:
  - BR, JAL, JALR: 3 cycles.
  - R, I, LUI, AUIPC, ST: 4 cycles.
  - LD: 5 cycles.
- A request stays high until its ack is sampled. Any ack seen outside FETCH or MEM is ignored.
- `ir_we` and `pc_we` are single-cycle pulses. `pc_we` is never high in two consecutive cycles.

## Test plan
- R-type (opcode 0110011), imem_ack in the same cycle → states 0, 1, 2, 4, 0; `reg_we` = 1 and `pc_we` = 1 in cycle 4 only; `instret` = 1.
- LW (0000011) with dmem_ack delayed 3 cycles → `dmem_req` high for 4 cycles with `dmem_we` = 0; WB has `wb_sel` = 1; total latency 8 cycles.
- BEQ (1100011):
  - `branch_taken` = 1 → `pc_sel` = 1, `pc_we` = 1 in EXEC, 3-cycle retire.
  - `branch_taken` = 0 → `pc_sel` = 0.
- Illegal opcode 1111111 → TRAP after DECODE, `fault` = 1, `fault_code` = 1, no `pc_we`. Hold 10 cycles, then `rst_n` = 0 for 1 cycle → `state` = 0, `fault_code` = 0, `imem_req` = 1.
- MEM_TIMEOUT = 4 and imem_ack never arrives → TRAP with `fault_code` = 2 after 5 FETCH cycles. A repeat run with the ack on the 5th FETCH cycle → DECODE, no fault.
- `instret` preloaded to 0xFFFFFFFF by forcing, then one JAL → `instret` = 0; `reg_we` = 1 with `wb_sel` = 2 and `pc_sel` = 2 in EXEC.

Source files
------------

// File: rtl/rv_multicycle_ctrl_if.sv
// Handshake, datapath-control and status bundle between the RV32I multi-cycle
// controller (master) and the datapath/memories (slave).
interface rv_multicycle_ctrl_if;
  logic [6:0]  opcode;
  logic        branch_taken;
  logic        imem_ack;
  logic        dmem_ack;
  logic        imem_req;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        alu_a_sel;
  logic        alu_b_sel;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic        dmem_req;
  logic        dmem_we;
  logic        fault;
  logic [1:0]  fault_code;
  logic [31:0] instret;
  logic [2:0]  state;

  modport master (
    input  opcode, branch_taken, imem_ack, dmem_ack,
    output imem_req, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel, reg_we,
           wb_sel, dmem_req, dmem_we, fault, fault_code, instret, state
  );

  modport slave (
    output opcode, branch_taken, imem_ack, dmem_ack,
    input  imem_req, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel, reg_we,
           wb_sel, dmem_req, dmem_we, fault, fault_code, instret, state
  );
endinterface

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/writeback sequencing,
// memory handshakes with time-out, illegal-opcode trap and retired-instruction count.
module rv_multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rv_multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    C_R, C_I, C_LD, C_ST, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC
  } cls_e;

  typedef enum logic [1:0] {
    F_NONE = 2'd0, F_ILLEGAL = 2'd1, F_IMEM_TO = 2'd2, F_DMEM_TO = 2'd3
  } fault_e;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0, PC_BRANCH = 2'd1, PC_JAL = 2'd2, PC_JALR = 2'd3
  } pc_sel_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0, WB_MEM = 2'd1, WB_LINK = 2'd2, WB_LUI = 2'd3
  } wb_sel_e;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  cls_e        cls_q, cls_d;
  fault_e      fcode_q, fcode_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] instret_q;

  cls_e        dec_cls;
  logic        legal;
  logic        imem_req, ir_we, pc_we, alu_a_sel, alu_b_sel, reg_we, dmem_req, dmem_we;
  pc_sel_e     pc_sel;
  wb_sel_e     wb_sel;

  always_comb begin
    legal   = 1'b1;
    dec_cls = C_R;
    unique case (bus.opcode)
      7'b0110011: dec_cls = C_R;
      7'b0010011: dec_cls = C_I;
      7'b0000011: dec_cls = C_LD;
      7'b0100011: dec_cls = C_ST;
      7'b1100011: dec_cls = C_BR;
      7'b1101111: dec_cls = C_JAL;
      7'b1100111: dec_cls = C_JALR;
      7'b0110111: dec_cls = C_LUI;
      7'b0010111: dec_cls = C_AUIPC;
      default:    legal   = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    fcode_d   = fcode_q;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = WB_ALU;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ack) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == TIMEOUT) begin
          state_d = S_TRAP;
          fcode_d = F_IMEM_TO;
        end
      end
      S_DECODE: begin
        if (legal) begin
          cls_d   = dec_cls;
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          fcode_d = F_ILLEGAL;
        end
      end
      S_EXEC: begin
        state_d = S_WB;
        unique case (cls_q)
          C_I:     alu_b_sel = 1'b1;
          C_LD, C_ST: begin
            alu_b_sel = 1'b1;
            state_d   = S_MEM;
          end
          C_AUIPC: begin
            alu_a_sel = 1'b1;
            alu_b_sel = 1'b1;
          end
          C_BR: begin
            pc_we   = 1'b1;
            pc_sel  = bus.branch_taken ? PC_BRANCH : PC_PLUS4;
            state_d = S_FETCH;
          end
          C_JAL: begin
            pc_we   = 1'b1;
            pc_sel  = PC_JAL;
            reg_we  = 1'b1;
            wb_sel  = WB_LINK;
            state_d = S_FETCH;
          end
          C_JALR: begin
            alu_b_sel = 1'b1;
            pc_we     = 1'b1;
            pc_sel    = PC_JALR;
            reg_we    = 1'b1;
            wb_sel    = WB_LINK;
            state_d   = S_FETCH;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        dmem_req  = 1'b1;
        dmem_we   = (cls_q == C_ST);
        alu_b_sel = 1'b1;
        if (bus.dmem_ack) begin
          // A store retires here; only loads need the writeback cycle.
          if (cls_q == C_ST) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == TIMEOUT) begin
          state_d = S_TRAP;
          fcode_d = F_DMEM_TO;
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        state_d = S_FETCH;
        unique case (cls_q)
          C_LD:    wb_sel = WB_MEM;
          C_LUI:   wb_sel = WB_LUI;
          C_I:     alu_b_sel = 1'b1;
          C_AUIPC: begin
            alu_a_sel = 1'b1;
            alu_b_sel = 1'b1;
          end
          default: ;
        endcase
      end
      S_TRAP: ;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    if (state_d != state_q) begin
      wait_d = '0;
    end else if ((state_q == S_FETCH && !bus.imem_ack) || (state_q == S_MEM && !bus.dmem_ack)) begin
      wait_d = wait_q + 8'd1;
    end else begin
      wait_d = wait_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cls_q     <= C_R;
      fcode_q   <= F_NONE;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      fcode_q   <= fcode_d;
      wait_q    <= wait_d;
      instret_q <= instret_q + 32'(pc_we);
    end
  end

  assign bus.imem_req   = imem_req;
  assign bus.ir_we      = ir_we;
  assign bus.pc_we      = pc_we;
  assign bus.pc_sel     = pc_sel;
  assign bus.alu_a_sel  = alu_a_sel;
  assign bus.alu_b_sel  = alu_b_sel;
  assign bus.reg_we     = reg_we;
  assign bus.wb_sel     = wb_sel;
  assign bus.dmem_req   = dmem_req;
  assign bus.dmem_we    = dmem_we;
  assign bus.fault      = (state_q == S_TRAP);
  assign bus.fault_code = fcode_q;
  assign bus.instret    = instret_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Randomized bench for rv_multicycle_ctrl: each instruction is expanded into its
// expected per-cycle trace (state, control word, fault code) and replayed cycle by cycle.
module tb_rv_multicycle_ctrl;

  localparam int unsigned TO = 4;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] LEGAL [9] = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
  localparam logic [6:0] ILLEGAL [4] = '{7'h7F, 7'h00, 7'h0F, 7'h73};

  // control word: imem_req ir_we pc_we pc_sel[2] alu_a alu_b reg_we wb_sel[2] dmem_req dmem_we fault 0
  localparam logic [13:0] IREQ = 14'h2000;
  localparam logic [13:0] IRWE = 14'h1000;
  localparam logic [13:0] PCWE = 14'h0800;
  localparam logic [13:0] ASEL = 14'h0100;
  localparam logic [13:0] BSEL = 14'h0080;
  localparam logic [13:0] RWE  = 14'h0040;
  localparam logic [13:0] DREQ = 14'h0008;
  localparam logic [13:0] DWE  = 14'h0004;
  localparam logic [13:0] FLT  = 14'h0002;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv_multicycle_ctrl_if bus ();
  rv_multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int unsigned total = 0;
  int unsigned bad = 0;
  logic [31:0] m_instret = '0;

  typedef struct {
    logic [2:0]  st;
    logic [13:0] ctl;
    logic [1:0]  fc;
    logic        ia;
    logic        da;
    logic [6:0]  op;
    logic        bt;
  } cyc_t;
  cyc_t q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  function automatic logic [13:0] ps(input int unsigned n);
    return 14'(n) << 9;
  endfunction

  function automatic logic [13:0] ws(input int unsigned n);
    return 14'(n) << 4;
  endfunction

  function automatic void put(input logic [2:0] st, input logic [13:0] ctl, input logic [1:0] fc,
                              input logic ia, input logic da);
    cyc_t c;
    c.st = st; c.ctl = ctl; c.fc = fc; c.ia = ia; c.da = da;
    c.op = 7'($urandom); c.bt = rnd();
    q.push_back(c);
  endfunction

  function automatic void trap(input logic [1:0] code, input int unsigned hold);
    for (int unsigned k = 0; k < hold; k++) put(3'd7, FLT, code, rnd(), rnd());
  endfunction

  // di/dd: ack delay in cycles; a delay above TO means the ack never comes
  function automatic void build(input logic [6:0] op, input logic bt, input int unsigned di,
                                input int unsigned dd, input int unsigned hold);
    bit is_st;
    q.delete();
    for (int unsigned k = 0; k <= di && k <= TO; k++)
      put(3'd0, IREQ | ((k == di) ? IRWE : 14'h0), 2'd0, k == di, rnd());
    if (di > TO) begin
      trap(2'd2, hold);
      return;
    end
    put(3'd1, 14'h0, 2'd0, rnd(), rnd());
    q[q.size()-1].op = op;
    case (op)
      OP_R:     begin put(3'd2, 14'h0, 0, rnd(), rnd()); put(3'd4, RWE | PCWE, 0, rnd(), rnd()); end
      OP_I:     begin put(3'd2, BSEL, 0, rnd(), rnd()); put(3'd4, BSEL | RWE | PCWE, 0, rnd(), rnd()); end
      OP_AUIPC: begin
        put(3'd2, ASEL | BSEL, 0, rnd(), rnd());
        put(3'd4, ASEL | BSEL | RWE | PCWE, 0, rnd(), rnd());
      end
      OP_LUI:   begin put(3'd2, 14'h0, 0, rnd(), rnd()); put(3'd4, RWE | PCWE | ws(3), 0, rnd(), rnd()); end
      OP_BR:    begin
        put(3'd2, PCWE | (bt ? ps(1) : 14'h0), 0, rnd(), rnd());
        q[q.size()-1].bt = bt;
      end
      OP_JAL:   put(3'd2, PCWE | ps(2) | RWE | ws(2), 0, rnd(), rnd());
      OP_JALR:  put(3'd2, BSEL | PCWE | ps(3) | RWE | ws(2), 0, rnd(), rnd());
      OP_LD, OP_ST: begin
        is_st = (op == OP_ST);
        put(3'd2, BSEL, 0, rnd(), rnd());
        for (int unsigned k = 0; k <= dd && k <= TO; k++)
          put(3'd3, DREQ | BSEL | (is_st ? DWE : 14'h0) | ((is_st && k == dd) ? PCWE : 14'h0),
              0, rnd(), k == dd);
        if (dd > TO) trap(2'd3, hold);
        else if (!is_st) put(3'd4, RWE | PCWE | ws(1), 0, rnd(), rnd());
      end
      default:  trap(2'd1, hold);
    endcase
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.imem_ack = rnd();
    bus.dmem_ack = rnd();
    bus.opcode = 7'($urandom);
    bus.branch_taken = rnd();
    m_instret = '0;
  endtask

  // abort: -1 run full trace, -2 random cut point, else reset in that cycle
  task automatic run(input logic [6:0] op, input logic bt, input int unsigned di, input int unsigned dd,
                     input int unsigned hold, input int abort, input bit preload);
    int cut;
    logic [13:0] ctl;
    build(op, bt, di, dd, hold);
    cut = abort;
    if (abort == -2 && q.size() > 1) cut = $urandom_range(1, q.size() - 1);
    else if (abort < 0) cut = -1;
    for (int i = 0; i < q.size(); i++) begin
      if (cut >= 0 && i == cut) break;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.opcode = q[i].op;
      bus.branch_taken = q[i].bt;
      bus.imem_ack = q[i].ia;
      bus.dmem_ack = q[i].da;
      if (preload && i == 0) begin
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        m_instret = 32'hFFFF_FFFF;
      end
      @(negedge clk);
      ctl = {bus.imem_req, bus.ir_we, bus.pc_we, bus.pc_sel, bus.alu_a_sel, bus.alu_b_sel,
             bus.reg_we, bus.wb_sel, bus.dmem_req, bus.dmem_we, bus.fault, 1'b0};
      check("state", 32'(bus.state), 32'(q[i].st));
      check("ctl", 32'(ctl), 32'(q[i].ctl));
      check("fault_code", 32'(bus.fault_code), 32'(q[i].fc));
      check("instret", bus.instret, m_instret);
      if (q[i].ctl[11]) m_instret = m_instret + 32'd1;
    end
    if (cut >= 0 || q[q.size()-1].st == 3'd7) do_reset();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned di, dd;
    logic [6:0] op;
    bus.opcode = '0;
    bus.branch_taken = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    repeat (2) @(posedge clk);

    run(OP_R, 0, 0, 0, 0, -1, 0);
    run(OP_LD, 0, 0, 3, 0, -1, 0);
    run(OP_BR, 1, 0, 0, 0, -1, 0);
    run(OP_BR, 0, 0, 0, 0, -1, 0);
    run(7'h7F, 0, 0, 0, 10, -1, 0);
    run(OP_R, 0, TO + 1, 0, 3, -1, 0);
    run(OP_R, 0, TO, 0, 0, -1, 0);
    run(OP_ST, 0, 1, TO + 1, 3, -1, 0);
    run(OP_ST, 0, 0, TO, 0, -1, 0);
    run(OP_JAL, 0, 0, 0, 0, -1, 1);
    run(OP_I, 0, 2, 0, 0, -1, 0);
    run(OP_LD, 0, 0, 3, 0, 5, 0);
    run(OP_AUIPC, 0, 0, 0, 0, -1, 0);
    run(OP_LUI, 0, 1, 0, 0, -1, 0);
    run(OP_JALR, 0, 0, 0, 0, -1, 0);

    for (int n = 0; n < 300; n++) begin
      op = ($urandom_range(0, 11) == 0) ? ILLEGAL[$urandom_range(0, 3)] : LEGAL[$urandom_range(0, 8)];
      di = ($urandom_range(0, 9) == 0) ? TO + 1 : $urandom_range(0, TO);
      dd = ($urandom_range(0, 9) == 0) ? TO + 1 : $urandom_range(0, TO);
      run(op, rnd(), di, dd, $urandom_range(1, 5), ($urandom_range(0, 9) == 0) ? -2 : -1, 0);
    end
    run(OP_R, 0, 0, 0, 0, -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
